// File: rtl/ddr_req_scheduler.sv
// DDR2 request scheduler: arbitrates ring ops against display reads, tags each read and
// steers returned RB data to the display or the ring. Define DDR_SCHED_STATS_EN for issue counters.
module ddr_req_scheduler #(
    parameter int MAX_OUT      = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         op_empty,
    input  logic [31:0]  op_word,
    input  logic [3:0]   op_dest,
    output logic         op_rd,
    input  logic         wd_empty,
    input  logic [127:0] wd_data,
    output logic         wd_rd,
    input  logic         dc_req,
    input  logic [25:0]  dc_addr,
    output logic         dc_ack,
    output logic         af_wr,
    output logic [25:0]  af_addr,
    output logic         af_read,
    input  logic         af_full,
    output logic         wb_wr,
    output logic [127:0] wb_data,
    input  logic         wb_full,
    input  logic         rb_empty,
    input  logic [127:0] rb_data,
    output logic         rb_rd,
    output logic         dc_rd_valid,
    output logic [127:0] dc_rd_data,
    output logic [31:0]  rd_return,
    output logic [3:0]   rd_dest,
    output logic         err_orphan,
    output logic [31:0]  stat_reads,
    output logic [31:0]  stat_writes
);

    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_DC   = 2'd1;
    localparam logic [1:0] R_RING = 2'd2;

    logic [CW-1:0]  outstanding;
    logic [SW-1:0]  starveCnt;
    logic [3:0]     tagMem [MAX_OUT];
    logic [PW-1:0]  wrPtr;
    logic [PW-1:0]  rdPtr;
    logic [1:0]     retState;
    logic [1:0]     wordIdx;
    logic [127:0]   retData;
    logic [3:0]     retTag;

    logic canRead, dcElig, ringRdElig, ringWrElig, ringElig;
    logic starveHit, ringGrant, dcGrant, ringWrGrant, tagPush, tagPop;
    logic unusedOpBits;

    assign unusedOpBits = ^op_word[31:27];

    assign canRead    = outstanding < CW'(MAX_OUT);
    assign dcElig     = dc_req & ~af_full & canRead;
    assign ringRdElig = ~op_empty & op_word[26] & ~af_full & canRead;
    assign ringWrElig = ~op_empty & ~op_word[26] & ~wd_empty & ~af_full & ~wb_full;
    assign ringElig   = ringRdElig | ringWrElig;
    assign starveHit  = starveCnt == SW'(STARVE_LIMIT);

    // Ring yields to display only until the display has had its run of grants
    assign ringGrant   = ringElig & (~dcElig | starveHit);
    assign dcGrant     = dcElig & ~ringGrant;
    assign ringWrGrant = ringGrant & ~op_word[26];
    assign tagPush     = (ringGrant & op_word[26]) | dcGrant;
    assign tagPop      = (retState == R_IDLE) & ~rb_empty & (outstanding != '0);

    assign op_rd  = ringGrant;
    assign wd_rd  = ringWrGrant;
    assign dc_ack = dcGrant;
    assign rb_rd  = tagPop;

    always_ff @(posedge clock) begin
        if (reset) begin
            af_wr   <= 1'b0;
            af_addr <= '0;
            af_read <= 1'b0;
            wb_wr   <= 1'b0;
            wb_data <= '0;
        end else begin
            af_wr <= ringGrant | dcGrant;
            wb_wr <= ringWrGrant;
            if (ringGrant) begin
                af_addr <= op_word[25:0];
                af_read <= op_word[26];
            end else if (dcGrant) begin
                af_addr <= dc_addr;
                af_read <= 1'b1;
            end
            if (ringWrGrant)
                wb_data <= wd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            starveCnt <= '0;
        else if (ringGrant || !ringElig)
            starveCnt <= '0;
        else if (dcGrant && !starveHit)
            starveCnt <= starveCnt + SW'(1);
    end

    // Tag 0 marks a display read; ring reads carry their nonzero source id
    always_ff @(posedge clock) begin
        if (tagPush)
            tagMem[wrPtr] <= dcGrant ? 4'd0 : op_dest;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            outstanding <= '0;
        end else begin
            if (tagPush)
                wrPtr <= wrPtr + PW'(1);
            if (tagPop)
                rdPtr <= rdPtr + PW'(1);
            if (tagPush && !tagPop)
                outstanding <= outstanding + CW'(1);
            else if (!tagPush && tagPop)
                outstanding <= outstanding - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            retState   <= R_IDLE;
            wordIdx    <= '0;
            retData    <= '0;
            retTag     <= '0;
            err_orphan <= 1'b0;
        end else begin
            case (retState)
                R_IDLE: begin
                    if (tagPop) begin
                        retData  <= rb_data;
                        retTag   <= tagMem[rdPtr];
                        wordIdx  <= '0;
                        retState <= (tagMem[rdPtr] == 4'd0) ? R_DC : R_RING;
                    end else if (!rb_empty) begin
                        err_orphan <= 1'b1;
                    end
                end
                R_DC: retState <= R_IDLE;
                R_RING: begin
                    wordIdx <= wordIdx + 2'd1;
                    if (wordIdx == 2'd3)
                        retState <= R_IDLE;
                end
                default: retState <= R_IDLE;
            endcase
        end
    end

    assign dc_rd_valid = retState == R_DC;
    assign dc_rd_data  = retData;
    assign rd_return   = (retState == R_RING) ? retData[{wordIdx, 5'd0} +: 32] : 32'd0;
    assign rd_dest     = (retState == R_RING) ? retTag : 4'd0;

`ifdef DDR_SCHED_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
        end else begin
            if (tagPush)
                stat_reads <= stat_reads + 32'd1;
            if (ringWrGrant)
                stat_writes <= stat_writes + 32'd1;
        end
    end
`else
    assign stat_reads  = 32'd0;
    assign stat_writes = 32'd0;
`endif

endmodule
